// File: rtl/udp_pkg.sv
// Shared constants, FSM state type and byte-lane helper for the UDP payload
// unpacker and the register bank it feeds.
package udp_pkg;

  localparam int UDP_NUM_WORDS     = 8;
  localparam int UDP_PAYLOAD_BYTES = 32;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    COLLECT,
    DRAIN
  } state_t;

  // Big-endian lane mapping: lane 0 is the most significant byte of a word.
  function automatic logic [4:0] byte_lane_lsb(input logic [1:0] lane);
    return {~lane, 3'b000};
  endfunction

endpackage

// File: rtl/udp_payload_unpacker_if.sv
// Avalon-ST 8-bit byte stream with sop/eop framing, as delivered by the
// Ethernet receive path.
interface udp_payload_unpacker_if;

  logic [7:0] st_data;
  logic       st_valid;
  logic       st_sop;
  logic       st_eop;
  logic       st_error;
  logic       st_ready;

  modport master (
    output st_data,
    output st_valid,
    output st_sop,
    output st_eop,
    output st_error,
    input  st_ready
  );

  modport slave (
    input  st_data,
    input  st_valid,
    input  st_sop,
    input  st_eop,
    input  st_error,
    output st_ready
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/udp_payload_unpacker.sv
// Skips an optional application header, assembles the next 32 payload bytes
// into eight big-endian words and publishes them only for clean packets.
module udp_payload_unpacker
  import udp_pkg::*;
#(
  parameter int HEADER_BYTES = 0,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  udp_payload_unpacker_if.slave st,
  output logic [31:0]           reg_0,
  output logic [31:0]           reg_1,
  output logic [31:0]           reg_2,
  output logic [31:0]           reg_3,
  output logic [31:0]           reg_4,
  output logic [31:0]           reg_5,
  output logic [31:0]           reg_6,
  output logic [31:0]           reg_7,
  output logic                  udp_data_valid,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      drop_count
);

  localparam logic [7:0] HDR_LAST = 8'(HEADER_BYTES - 1);
  localparam logic [4:0] LAST_IDX = 5'(UDP_PAYLOAD_BYTES - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  skip_cnt;
  logic [4:0]  byte_idx;
  logic [4:0]  wr_idx;
  logic [31:0] shadow      [UDP_NUM_WORDS];
  logic [31:0] shadow_next [UDP_NUM_WORDS];
  logic [31:0] pub         [UDP_NUM_WORDS];
  logic        store;
  logic        commit;
  logic        drop_abort;
  logic        drop_pkt;
  logic        drop_pending;
  logic        drop_inc;

  assign st.st_ready = 1'b1;

  always_comb begin
    next_state = state;
    store      = 1'b0;
    commit     = 1'b0;
    drop_abort = 1'b0;
    drop_pkt   = 1'b0;
    if (st.st_valid) begin
      if (st.st_sop) begin
        drop_abort = (state != IDLE);
        if (HEADER_BYTES == 0) begin
          store      = 1'b1;
          next_state = COLLECT;
        end else if (HEADER_BYTES == 1) begin
          next_state = COLLECT;
        end else begin
          next_state = SKIP;
        end
        if (st.st_eop) begin
          drop_pkt   = 1'b1;
          next_state = IDLE;
        end
      end else begin
        case (state)
          SKIP: begin
            if (st.st_eop) begin
              drop_pkt   = 1'b1;
              next_state = IDLE;
            end else if (skip_cnt == HDR_LAST) begin
              next_state = COLLECT;
            end
          end
          COLLECT: begin
            store = 1'b1;
            if (byte_idx == LAST_IDX) begin
              if (!st.st_eop) begin
                next_state = DRAIN;
              end else if (st.st_error) begin
                drop_pkt   = 1'b1;
                next_state = IDLE;
              end else begin
                commit     = 1'b1;
                next_state = IDLE;
              end
            end else if (st.st_eop) begin
              drop_pkt   = 1'b1;
              next_state = IDLE;
            end
          end
          DRAIN: begin
            if (st.st_eop) begin
              drop_pkt   = !st.st_error;
              drop_pkt   = st.st_error;
              commit     = !st.st_error;
              next_state = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The byte being stored this beat is merged in here so that a commit on
  // byte 31 publishes it in the same cycle.
  assign wr_idx = st.st_sop ? 5'd0 : byte_idx;

  always_comb begin
    shadow_next = shadow;
    if (store) begin
      shadow_next[wr_idx[4:2]][byte_lane_lsb(wr_idx[1:0]) +: 8] = st.st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      skip_cnt       <= '0;
      byte_idx       <= '0;
      udp_data_valid <= 1'b0;
      shadow         <= '{default: '0};
      pub            <= '{default: '0};
    end else begin
      state          <= next_state;
      udp_data_valid <= commit;
      shadow         <= shadow_next;
      if (commit) begin
        pub <= shadow_next;
      end
      if (st.st_valid && st.st_sop) begin
        skip_cnt <= 8'd1;
        byte_idx <= (HEADER_BYTES == 0) ? 5'd1 : 5'd0;
      end else begin
        if (st.st_valid && (state == SKIP)) begin
          skip_cnt <= skip_cnt + 8'd1;
        end
        if (store) begin
          byte_idx <= byte_idx + 5'd1;
        end
      end
    end
  end

  // An aborting sop that is also a one-byte packet drops twice; the second
  // increment is carried into the next cycle.
  assign drop_inc = drop_abort | drop_pkt | drop_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pending <= 1'b0;
    end else begin
      drop_pending <= (drop_abort & drop_pkt) | (drop_pending & (drop_abort | drop_pkt));
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (commit),
    .count (pkt_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_count)
  );

  assign reg_0 = pub[0];
  assign reg_1 = pub[1];
  assign reg_2 = pub[2];
  assign reg_3 = pub[3];
  assign reg_4 = pub[4];
  assign reg_5 = pub[5];
  assign reg_6 = pub[6];
  assign reg_7 = pub[7];

endmodule
